// File: rtl/packet_snooper_pkg.sv
// Shared definitions for the P3 snooper/forwarder pair: FSM state encoding and
// a TKEEP popcount helper.
package packet_snooper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FLUSH,
    ST_DONE,
    ST_DROP
  } sn_state_t;

  // Widest byte-enable vector supported (DATA_WIDTH up to 512).
  localparam int unsigned MAX_KEEP_WIDTH = 64;

  function automatic int unsigned popcount(input logic [MAX_KEEP_WIDTH-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/packet_snooper_keep_popcount.sv
// Combinational byte counter: number of set TKEEP bits, sized to INC_WIDTH.
module keep_popcount
  import packet_snooper_pkg::*;
#(
  parameter int unsigned KEEP_WIDTH = 8,
  parameter int unsigned INC_WIDTH  = 8
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [INC_WIDTH-1:0]  count
);

  logic [MAX_KEEP_WIDTH-1:0] keep_ext;

  assign keep_ext = MAX_KEEP_WIDTH'(keep);
  assign count    = INC_WIDTH'(popcount(keep_ext));

endmodule

// File: rtl/packet_snooper.sv
// Passive AXI-Stream tap that copies whole packets into the P3 buffer offered
// to the snooper, dropping (and counting) packets when no buffer is available.
module packet_snooper
  import packet_snooper_pkg::*;
#(
  parameter int unsigned SN_ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned INC_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    snoop_TDATA,
  input  logic [DATA_WIDTH/8-1:0]  snoop_TKEEP,
  input  logic                     snoop_TLAST,
  input  logic                     snoop_TVALID,
  input  logic                     snoop_TREADY,
  output logic [SN_ADDR_WIDTH-1:0] sn_addr,
  output logic [DATA_WIDTH-1:0]    sn_wr_data,
  output logic                     sn_wr_en,
  output logic [INC_WIDTH-1:0]     sn_byte_inc,
  input  logic                     rdy_for_sn,
  output logic                     rdy_for_sn_ack,
  output logic                     sn_done,
  input  logic                     sn_done_ack,
  output logic [31:0]              drop_cnt
);

  localparam logic [SN_ADDR_WIDTH-1:0] ADDR_MAX = '1;

  sn_state_t                state;
  logic                     sop;
  logic                     pend_drop;
  logic                     pend_next;
  logic                     full;
  logic                     beat;
  logic [SN_ADDR_WIDTH-1:0] wr_ptr;
  logic [INC_WIDTH-1:0]     keep_cnt;
  logic [31:0]              drop_sat;

  keep_popcount #(
    .KEEP_WIDTH(DATA_WIDTH/8),
    .INC_WIDTH (INC_WIDTH)
  ) u_keep_popcount (
    .keep (snoop_TKEEP),
    .count(keep_cnt)
  );

  assign beat     = snoop_TVALID & snoop_TREADY;
  assign drop_sat = (drop_cnt == '1) ? drop_cnt : drop_cnt + 32'd1;

  // Tracks whether a packet dropped during FLUSH/DONE is still in flight,
  // including a beat that arrives in the same cycle as the done ack.
  always_comb begin
    pend_next = pend_drop;
    if (beat) begin
      if (sop)              pend_next = ~snoop_TLAST;
      else if (snoop_TLAST) pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      sop            <= 1'b1;
      pend_drop      <= 1'b0;
      full           <= 1'b0;
      wr_ptr         <= '0;
      sn_addr        <= '0;
      sn_wr_data     <= '0;
      sn_wr_en       <= 1'b0;
      sn_byte_inc    <= '0;
      rdy_for_sn_ack <= 1'b0;
      sn_done        <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      sn_wr_en       <= 1'b0;
      rdy_for_sn_ack <= 1'b0;
      if (beat) sop <= snoop_TLAST;

      case (state)
        ST_IDLE: begin
          if (beat && sop) begin
            if (rdy_for_sn) begin
              rdy_for_sn_ack <= 1'b1;
              sn_wr_en       <= 1'b1;
              sn_addr        <= '0;
              sn_wr_data     <= snoop_TDATA;
              sn_byte_inc    <= keep_cnt;
              wr_ptr         <= SN_ADDR_WIDTH'(1);
              full           <= 1'b0;
              pend_drop      <= 1'b0;
              state          <= snoop_TLAST ? ST_FLUSH : ST_WRITE;
            end else begin
              drop_cnt <= drop_sat;
              if (!snoop_TLAST) state <= ST_DROP;
            end
          end
        end

        ST_WRITE: begin
          if (beat) begin
            // Past the last address the packet is truncated, never wrapped.
            if (!full) begin
              sn_wr_en    <= 1'b1;
              sn_addr     <= wr_ptr;
              sn_wr_data  <= snoop_TDATA;
              sn_byte_inc <= keep_cnt;
              if (wr_ptr == ADDR_MAX) full   <= 1'b1;
              else                    wr_ptr <= wr_ptr + SN_ADDR_WIDTH'(1);
            end
            if (snoop_TLAST) begin
              pend_drop <= 1'b0;
              state     <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          if (beat && sop) drop_cnt <= drop_sat;
          pend_drop <= pend_next;
          sn_done   <= 1'b1;
          state     <= ST_DONE;
        end

        ST_DONE: begin
          if (beat && sop) drop_cnt <= drop_sat;
          pend_drop <= pend_next;
          if (sn_done_ack) begin
            sn_done <= 1'b0;
            state   <= pend_next ? ST_DROP : ST_IDLE;
          end
        end

        ST_DROP: begin
          if (beat && snoop_TLAST) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_snooper.sv
// Directed bench for packet_snooper: a cycle table plus hand-written sequences
// for reset, truncation, done stalls and drop-counter saturation.
module tb_packet_snooper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;
  logic        rdy, done_ack;

  logic [8:0]  addr;
  logic [63:0] wr_data;
  logic        wr_en;
  logic [7:0]  byte_inc;
  logic        ack;
  logic        done;
  logic [31:0] drops;

  logic [1:0]  n_addr;
  logic [63:0] n_wr_data;
  logic        n_wr_en;
  logic [7:0]  n_byte_inc;
  logic        n_ack;
  logic        n_done;
  logic [31:0] n_drops;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  packet_snooper #(.SN_ADDR_WIDTH(9), .DATA_WIDTH(64), .INC_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_TDATA(tdata), .snoop_TKEEP(tkeep), .snoop_TLAST(tlast),
    .snoop_TVALID(tvalid), .snoop_TREADY(tready),
    .sn_addr(addr), .sn_wr_data(wr_data), .sn_wr_en(wr_en), .sn_byte_inc(byte_inc),
    .rdy_for_sn(rdy), .rdy_for_sn_ack(ack),
    .sn_done(done), .sn_done_ack(done_ack), .drop_cnt(drops)
  );

  packet_snooper #(.SN_ADDR_WIDTH(2), .DATA_WIDTH(64), .INC_WIDTH(8)) dut_narrow (
    .clk(clk), .rst_n(rst_n),
    .snoop_TDATA(tdata), .snoop_TKEEP(tkeep), .snoop_TLAST(tlast),
    .snoop_TVALID(tvalid), .snoop_TREADY(tready),
    .sn_addr(n_addr), .sn_wr_data(n_wr_data), .sn_wr_en(n_wr_en), .sn_byte_inc(n_byte_inc),
    .rdy_for_sn(rdy), .rdy_for_sn_ack(n_ack),
    .sn_done(n_done), .sn_done_ack(done_ack), .drop_cnt(n_drops)
  );

  typedef struct packed {
    logic        v, l;
    logic [7:0]  keep;
    logic [63:0] data;
    logic        rdy, ack;
    logic        e_wr;
    logic [8:0]  e_addr;
    logic [63:0] e_data;
    logic [7:0]  e_inc;
    logic        e_ack, e_done;
    logic [31:0] e_drop;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic v, logic l, logic [7:0] keep, logic [63:0] data,
                              logic r, logic a, logic e_wr, logic [8:0] e_addr,
                              logic [63:0] e_data, logic [7:0] e_inc, logic e_ack,
                              logic e_done, logic [31:0] e_drop);
    vec_t t;
    t.v = v; t.l = l; t.keep = keep; t.data = data; t.rdy = r; t.ack = a;
    t.e_wr = e_wr; t.e_addr = e_addr; t.e_data = e_data; t.e_inc = e_inc;
    t.e_ack = e_ack; t.e_done = e_done; t.e_drop = e_drop;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [7:0] keep,
                       input logic [63:0] data, input logic r, input logic a);
    tvalid = v; tready = v; tlast = l; tkeep = keep; tdata = data;
    rdy = r; done_ack = a;
  endtask

  task automatic idle(input logic a);
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, a);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b0);

    vecs[0]  = mk(1, 0, 8'hFF, {8{8'hA0}}, 1, 0, 0, 0, 64'h0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 8'hFF, {8{8'hA1}}, 1, 0, 1, 0, {8{8'hA0}}, 8, 1, 0, 0);
    vecs[2]  = mk(1, 1, 8'h0F, {8{8'hA2}}, 1, 0, 1, 1, {8{8'hA1}}, 8, 0, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 64'h0,      1, 0, 1, 2, {8{8'hA2}}, 4, 0, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00, 64'h0,      1, 0, 0, 0, 64'h0, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 8'h00, 64'h0,      1, 1, 0, 0, 64'h0, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 8'hFF, {8{8'hB0}}, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 8'hFF, {8{8'hB1}}, 0, 0, 0, 0, 64'h0, 0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 8'hFF, {8{8'hB2}}, 1, 0, 0, 0, 64'h0, 0, 0, 0, 1);
    vecs[9]  = mk(1, 1, 8'hFF, {8{8'hB3}}, 1, 0, 0, 0, 64'h0, 0, 0, 0, 1);
    vecs[10] = mk(1, 1, 8'h03, {8{8'hC0}}, 1, 0, 0, 0, 64'h0, 0, 0, 0, 1);
    vecs[11] = mk(0, 0, 8'h00, 64'h0,      1, 0, 1, 0, {8{8'hC0}}, 2, 1, 0, 1);
    vecs[12] = mk(0, 0, 8'h00, 64'h0,      1, 1, 0, 0, 64'h0, 0, 0, 1, 1);
    vecs[13] = mk(0, 0, 8'h00, 64'h0,      1, 0, 0, 0, 64'h0, 0, 0, 0, 1);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst wr_en", 64'(wr_en), 64'h0);
    check("rst addr", 64'(addr), 64'h0);
    check("rst data", wr_data, 64'h0);
    check("rst inc", 64'(byte_inc), 64'h0);
    check("rst ack", 64'(ack), 64'h0);
    check("rst done", 64'(done), 64'h0);
    check("rst drop", 64'(drops), 64'h0);
    rst_n = 1'b1;

    // Table: 3-beat packet, dropped 4-beat packet, 1-beat packet with same-cycle ack
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(vecs[i].e_wr));
      check($sformatf("v%0d n_wr_en", i), 64'(n_wr_en), 64'(vecs[i].e_wr));
      check($sformatf("v%0d ack", i), 64'(ack), 64'(vecs[i].e_ack));
      check($sformatf("v%0d done", i), 64'(done), 64'(vecs[i].e_done));
      check($sformatf("v%0d drop", i), 64'(drops), 64'(vecs[i].e_drop));
      if (vecs[i].e_wr) begin
        check($sformatf("v%0d addr", i), 64'(addr), 64'(vecs[i].e_addr));
        check($sformatf("v%0d data", i), wr_data, vecs[i].e_data);
        check($sformatf("v%0d inc", i), 64'(byte_inc), 64'(vecs[i].e_inc));
      end
      drive(vecs[i].v, vecs[i].l, vecs[i].keep, vecs[i].data, vecs[i].rdy, vecs[i].ack);
    end

    // Reset mid-packet; the remaining beats arrive while reset is held
    @(negedge clk);
    drive(1, 0, 8'hFF, {8{8'hD0}}, 1, 0);
    @(negedge clk);
    check("rm w0 wr_en", 64'(wr_en), 64'h1);
    check("rm w0 ack", 64'(ack), 64'h1);
    drive(1, 0, 8'hFF, {8{8'hD1}}, 1, 0);
    @(negedge clk);
    check("rm w1 addr", 64'(addr), 64'h1);
    rst_n = 1'b0;
    drive(1, 0, 8'hFF, {8{8'hD2}}, 1, 0);
    #1;
    check("rm async wr_en", 64'(wr_en), 64'h0);
    check("rm async addr", 64'(addr), 64'h0);
    check("rm async drop", 64'(drops), 64'h0);
    @(negedge clk);
    drive(1, 1, 8'hFF, {8{8'hD3}}, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 8'h01, {8{8'hE0}}, 1, 0);
    @(negedge clk);
    check("rm new wr_en", 64'(wr_en), 64'h1);
    check("rm new addr", 64'(addr), 64'h0);
    check("rm new data", wr_data, {8{8'hE0}});
    check("rm new inc", 64'(byte_inc), 64'h1);
    check("rm new ack", 64'(ack), 64'h1);
    idle(0);
    @(negedge clk);
    check("rm done", 64'(done), 64'h1);
    idle(1);
    @(negedge clk);
    check("rm done clr", 64'(done), 64'h0);
    check("rm drop", 64'(drops), 64'h0);
    idle(0);

    // 6-beat packet: the 2-bit-address instance stops at address 3
    for (int k = 0; k < 6; k++) begin
      drive(1, (k == 5), 8'hFF, 64'(k) + 64'hF0, 1, 0);
      @(negedge clk);
      check($sformatf("ov%0d wr_en", k), 64'(wr_en), 64'h1);
      check($sformatf("ov%0d addr", k), 64'(addr), 64'(k));
      check($sformatf("ov%0d n_wr_en", k), 64'(n_wr_en), (k < 4) ? 64'h1 : 64'h0);
      check($sformatf("ov%0d n_addr", k), 64'(n_addr), (k < 4) ? 64'(k) : 64'h3);
      if (k < 4) check($sformatf("ov%0d n_data", k), n_wr_data, 64'(k) + 64'hF0);
    end
    idle(0);
    @(negedge clk);
    check("ov done", 64'(done), 64'h1);
    check("ov n_done", 64'(n_done), 64'h1);
    check("ov n_addr hold", 64'(n_addr), 64'h3);
    idle(1);
    @(negedge clk);
    check("ov n_done clr", 64'(n_done), 64'h0);

    // Packet arriving while sn_done waits for its ack is dropped
    drive(1, 1, 8'hFF, {8{8'h11}}, 1, 0);
    @(negedge clk);
    check("st w0", 64'(wr_en), 64'h1);
    idle(0);
    @(negedge clk);
    check("st done", 64'(done), 64'h1);
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      drive(1, 0, 8'hFF, {8{8'h22}}, 1, 0);
      else if (c == 1) drive(1, 1, 8'hFF, {8{8'h23}}, 1, 0);
      else             idle(0);
      @(negedge clk);
      check($sformatf("st%0d done", c), 64'(done), 64'h1);
      check($sformatf("st%0d wr_en", c), 64'(wr_en), 64'h0);
      check($sformatf("st%0d drop", c), 64'(drops), 64'h1);
    end
    idle(1);
    @(negedge clk);
    check("st done clr", 64'(done), 64'h0);
    drive(1, 1, 8'h07, {8{8'h33}}, 1, 0);
    @(negedge clk);
    check("st next wr_en", 64'(wr_en), 64'h1);
    check("st next addr", 64'(addr), 64'h0);
    check("st next data", wr_data, {8{8'h33}});
    check("st next inc", 64'(byte_inc), 64'h3);
    check("st next ack", 64'(ack), 64'h1);
    idle(0);
    @(negedge clk);
    idle(1);
    @(negedge clk);
    check("st next done clr", 64'(done), 64'h0);

    // Drop counter saturation
    force dut.drop_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 8'hFF, 64'h0, 0, 0);
      @(negedge clk);
      check($sformatf("sat%0d drop", k), 64'(drops), 64'hFFFF_FFFF);
      check($sformatf("sat%0d wr_en", k), 64'(wr_en), 64'h0);
    end
    idle(0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
